// File: rtl/ps2_key_tx.sv
// Device-side PS/2 keyboard transmitter: queues toggle-strobe key events, expands each into
// set-2 scancode bytes ([E0] [F0] code) and sends them as device-to-host frames on
// open-drain clock/data lines.
module ps2_key_tx #(
  parameter int unsigned CLK_DIV    = 2000,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned GAP        = 4000
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic [10:0] ps2_key,
  input  logic        ps2_clk_in,
  output logic        ps2_clk_oe,
  output logic        ps2_dat_oe,
  output logic        busy,
  output logic        overflow
);

  localparam int unsigned AW     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntMax = (CLK_DIV > GAP) ? CLK_DIV : GAP;
  localparam int unsigned CW     = $clog2(CntMax + 1);

  localparam logic [CW-1:0] CntOne  = CW'(1);
  localparam logic [CW-1:0] DivLast = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] DivFull = CW'(CLK_DIV);
  localparam logic [CW-1:0] GapLast = CW'(GAP - 1);
  localparam logic [AW:0]   Depth   = (AW + 1)'(FIFO_DEPTH);
  localparam logic [AW-1:0] PtrOne  = AW'(1);
  localparam logic [AW:0]   CntInc  = (AW + 1)'(1);

  typedef enum logic [2:0] {StIdle, StSetup, StLow, StGap, StAbort} state_e;

  // Frame bit i: 0 start, 1..8 data LSB first, 9 odd parity, 10 stop.
  function automatic logic frame_bit(input logic [3:0] idx, input logic [7:0] b);
    logic r;
    r = 1'b1;
    if (idx == 4'd0) begin
      r = 1'b0;
    end else if (idx <= 4'd8) begin
      r = b[3'(idx - 4'd1)];
    end else if (idx == 4'd9) begin
      r = ~^b;
    end
    return r;
  endfunction

  logic [1:0]    clk_sync_q;
  logic          clk_hi;
  logic [CW-1:0] idle_cnt_q;
  logic          armed_q, last_tgl_q, ev_new;
  logic [9:0]    fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   fifo_cnt_q;
  logic          fifo_full, push, pop;
  logic          seq_valid_q, seq_e0_q, seq_f0_q;
  logic [7:0]    seq_code_q, cur_byte;
  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic [3:0]    bit_idx_q;
  logic          byte_done;

  assign clk_hi    = clk_sync_q[1];
  assign ev_new    = armed_q && (ps2_key[10] != last_tgl_q);
  assign fifo_full = (fifo_cnt_q == Depth);
  assign pop       = !seq_valid_q && (fifo_cnt_q != '0);
  // A pop in the same cycle frees a slot, so a write to a full FIFO is still accepted.
  assign push      = ev_new && (!fifo_full || pop);
  assign cur_byte  = seq_e0_q ? 8'hE0 : (seq_f0_q ? 8'hF0 : seq_code_q);
  assign busy      = (fifo_cnt_q != '0) || seq_valid_q || (state_q != StIdle);

  // Synchronise the sensed clock line and count how long it has been released and idle.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      clk_sync_q <= 2'b00;
      idle_cnt_q <= '0;
    end else begin
      clk_sync_q <= {clk_sync_q[0], ps2_clk_in};
      if (!clk_hi || ps2_clk_oe) begin
        idle_cnt_q <= '0;
      end else if (idle_cnt_q != DivFull) begin
        idle_cnt_q <= idle_cnt_q + CntOne;
      end
    end
  end

  // Toggle edge detection; the first cycle after reset only learns the current level.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      armed_q    <= 1'b0;
      last_tgl_q <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      armed_q    <= 1'b1;
      last_tgl_q <= ps2_key[10];
      overflow   <= ev_new && !push;
    end
  end

  // Event FIFO storage; contents are don't-care while unoccupied, so no reset.
  always_ff @(posedge clk_sys) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= ps2_key[9:0];
    end
  end

  // Event FIFO pointers and occupancy.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrOne;
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrOne;
      if (push && !pop) begin
        fifo_cnt_q <= fifo_cnt_q + CntInc;
      end else if (pop && !push) begin
        fifo_cnt_q <= fifo_cnt_q - CntInc;
      end
    end
  end

  // Byte completes at the end of the stop-bit LOW phase, or on an inhibit seen before the stop clock.
  always_comb begin
    byte_done = 1'b0;
    if (bit_idx_q == 4'd10) begin
      byte_done = (state_q == StAbort) || ((state_q == StLow) && (cnt_q == DivLast));
    end
  end

  // Byte sequencer: holds the current event and steps E0 -> F0 -> code as bytes complete.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      seq_valid_q <= 1'b0;
      seq_e0_q    <= 1'b0;
      seq_f0_q    <= 1'b0;
      seq_code_q  <= 8'h00;
    end else if (pop) begin
      seq_valid_q <= 1'b1;
      seq_e0_q    <= fifo_mem[rd_ptr_q][8];
      seq_f0_q    <= ~fifo_mem[rd_ptr_q][9];
      seq_code_q  <= fifo_mem[rd_ptr_q][7:0];
    end else if (byte_done) begin
      if (seq_e0_q) begin
        seq_e0_q <= 1'b0;
      end else if (seq_f0_q) begin
        seq_f0_q <= 1'b0;
      end else begin
        seq_valid_q <= 1'b0;
      end
    end
  end

  // Frame FSM with registered open-drain enables.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      bit_idx_q  <= 4'd0;
      ps2_clk_oe <= 1'b0;
      ps2_dat_oe <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (seq_valid_q && (idle_cnt_q == DivFull)) begin
            state_q    <= StSetup;
            cnt_q      <= '0;
            bit_idx_q  <= 4'd0;
            ps2_dat_oe <= ~frame_bit(4'd0, cur_byte);
          end
        end
        StSetup: begin
          if (cnt_q == DivLast) begin
            cnt_q <= '0;
            if (!clk_hi) begin
              // Host is inhibiting: back off and release both lines.
              state_q    <= StAbort;
              ps2_dat_oe <= 1'b0;
            end else begin
              state_q    <= StLow;
              ps2_clk_oe <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + CntOne;
          end
        end
        StLow: begin
          if (cnt_q == DivLast) begin
            cnt_q      <= '0;
            ps2_clk_oe <= 1'b0;
            if (bit_idx_q == 4'd10) begin
              state_q    <= StGap;
              ps2_dat_oe <= 1'b0;
            end else begin
              state_q    <= StSetup;
              bit_idx_q  <= bit_idx_q + 4'd1;
              ps2_dat_oe <= ~frame_bit(bit_idx_q + 4'd1, cur_byte);
            end
          end else begin
            cnt_q <= cnt_q + CntOne;
          end
        end
        StGap: begin
          if (cnt_q == GapLast) begin
            cnt_q   <= '0;
            state_q <= StIdle;
          end else begin
            cnt_q <= cnt_q + CntOne;
          end
        end
        StAbort: begin
          ps2_clk_oe <= 1'b0;
          ps2_dat_oe <= 1'b0;
          state_q    <= StIdle;
        end
        default: begin
          state_q    <= StIdle;
          ps2_clk_oe <= 1'b0;
          ps2_dat_oe <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_key_tx.sv
// Bench for ps2_key_tx: open-drain line model with pull-ups, host sampler on clock fall,
// and a byte-level reference model of the event-to-scancode expansion.
module tb_ps2_key_tx;

  localparam int unsigned CLK_DIV    = 4;
  localparam int unsigned FIFO_DEPTH = 4;
  localparam int unsigned GAP        = 8;

  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic [10:0] ps2_key;
  logic        host_hold = 1'b0;
  logic        ps2_clk_oe, ps2_dat_oe, busy, overflow;
  logic        clk_line, dat_line;

  assign clk_line = ~(ps2_clk_oe | host_hold);
  assign dat_line = ~ps2_dat_oe;

  ps2_key_tx #(
    .CLK_DIV   (CLK_DIV),
    .FIFO_DEPTH(FIFO_DEPTH),
    .GAP       (GAP)
  ) dut (
    .clk_sys   (clk_sys),
    .reset_n   (reset_n),
    .ps2_key   (ps2_key),
    .ps2_clk_in(clk_line),
    .ps2_clk_oe(ps2_clk_oe),
    .ps2_dat_oe(ps2_dat_oe),
    .busy      (busy),
    .overflow  (overflow)
  );

  always #5 clk_sys = ~clk_sys;

  int          checks   = 0;
  int          failures = 0;
  int          cyc      = 0;
  int          ovf_cnt  = 0;
  logic        bits_q[$];
  int          fall_q[$];
  logic [7:0]  exp_q[$];

  always @(posedge clk_sys) cyc <= cyc + 1;
  always @(negedge clk_sys) if (overflow) ovf_cnt <= ovf_cnt + 1;

  // Host samples data on each device-driven clock fall.
  always @(negedge clk_line) begin
    if (!host_hold) begin
      bits_q.push_back(dat_line);
      fall_q.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic odd_par(input logic [7:0] b);
    int ones;
    ones = 0;
    for (int j = 0; j < 8; j++) ones += int'(b[j]);
    return (ones % 2) == 0;
  endfunction

  task automatic model_push(input logic p, input logic e, input logic [7:0] c);
    if (e) exp_q.push_back(8'hE0);
    if (!p) exp_q.push_back(8'hF0);
    exp_q.push_back(c);
  endtask

  task automatic send_event(input logic p, input logic e, input logic [7:0] c, input bit accept);
    @(negedge clk_sys);
    ps2_key = {~ps2_key[10], p, e, c};
    if (accept) model_push(p, e, c);
  endtask

  task automatic clear_host();
    bits_q.delete();
    fall_q.delete();
  endtask

  task automatic wait_bits(input string tag, input int n);
    int budget;
    budget = 300;
    while (bits_q.size() < n && budget > 0) begin
      @(posedge clk_sys); #1;
      budget--;
    end
    check({tag, "_bits"}, 32'(bits_q.size() >= n), 1);
  endtask

  task automatic wait_clk_oe(input string tag, input logic lvl);
    int budget;
    budget = 50;
    @(negedge clk_sys);
    while (ps2_clk_oe !== lvl && budget > 0) begin
      @(negedge clk_sys);
      budget--;
    end
    check({tag, "_clk_oe"}, 32'(ps2_clk_oe), 32'(lvl));
  endtask

  // Collect every byte the model expects and check framing, content, parity and spacing.
  task automatic expect_all(input string tag);
    int n, budget, prev_stop, start_cyc, stop_cyc;
    logic [7:0] got, want;
    logic st, par, stp;
    n = exp_q.size();
    budget = 150 * n + 200;
    prev_stop = -1;
    while (bits_q.size() < 11 * n && budget > 0) begin
      @(posedge clk_sys); #1;
      budget--;
    end
    check({tag, "_frames"}, 32'(bits_q.size() >= 11 * n), 1);
    for (int k = 0; k < n; k++) begin
      if (bits_q.size() < 11) break;
      want = exp_q.pop_front();
      st = bits_q.pop_front();
      start_cyc = fall_q.pop_front();
      for (int j = 0; j < 8; j++) begin
        got[j] = bits_q.pop_front();
        void'(fall_q.pop_front());
      end
      par = bits_q.pop_front();
      void'(fall_q.pop_front());
      stp = bits_q.pop_front();
      stop_cyc = fall_q.pop_front();
      check({tag, "_start"}, 32'(st), 0);
      check({tag, "_byte"}, 32'(got), 32'(want));
      check({tag, "_parity"}, 32'(par), 32'(odd_par(want)));
      check({tag, "_stop"}, 32'(stp), 1);
      if (prev_stop >= 0) begin
        check({tag, "_gap"}, 32'((start_cyc - prev_stop) >= int'(CLK_DIV + GAP)), 1);
      end
      prev_stop = stop_cyc;
    end
    exp_q.delete();
  endtask

  task automatic settle(input string tag);
    int budget;
    budget = CLK_DIV + GAP + 40;
    while (busy && budget > 0) begin
      @(posedge clk_sys); #1;
      budget--;
    end
    check({tag, "_idle"}, 32'(busy), 0);
    check({tag, "_no_extra"}, 32'(bits_q.size()), 0);
    clear_host();
    repeat (CLK_DIV + 4) @(posedge clk_sys);
  endtask

  initial begin
    logic [7:0] code;
    logic [3:0] part;
    logic [7:0] part8;
    logic p, e;
    int w, rel, ovf_base;

    reset_n = 1'b0;
    ps2_key = 11'h000;
    #1;
    check("rst_clk_oe", 32'(ps2_clk_oe), 0);
    check("rst_dat_oe", 32'(ps2_dat_oe), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_overflow", 32'(overflow), 0);
    repeat (3) @(negedge clk_sys);
    reset_n = 1'b1;
    repeat (20) @(posedge clk_sys);

    // Press 0x29: first-frame latency, frame contents, busy through the gap.
    send_event(1'b1, 1'b0, 8'h29, 1'b1);
    @(posedge clk_sys); #1;
    check("lat_n1_dat", 32'(ps2_dat_oe), 0);
    check("lat_n1_busy", 32'(busy), 1);
    @(posedge clk_sys); #1;
    check("lat_n2_dat", 32'(ps2_dat_oe), 0);
    @(posedge clk_sys); #1;
    check("lat_n3_dat", 32'(ps2_dat_oe), 1);
    expect_all("press29");
    check("press29_busy_after_stop", 32'(busy), 1);
    w = 0;
    while (busy && w < int'(CLK_DIV + GAP + 20)) begin
      @(posedge clk_sys); #1;
      w++;
    end
    check("press29_busy_drop", 32'(busy), 0);
    check("press29_busy_gap", 32'(w >= int'(GAP)), 1);
    settle("press29");

    // Extended release of 0x6B -> E0 F0 6B.
    send_event(1'b0, 1'b1, 8'h6B, 1'b1);
    expect_all("rel6b");
    settle("rel6b");

    // Parity corner codes queued back to back.
    send_event(1'b1, 1'b0, 8'h00, 1'b1);
    send_event(1'b1, 1'b0, 8'hFF, 1'b1);
    send_event(1'b1, 1'b0, 8'h01, 1'b1);
    check("parity_00", 32'(odd_par(8'h00)), 1);
    check("parity_01", 32'(odd_par(8'h01)), 0);
    expect_all("parity");
    settle("parity");

    // Random events one at a time.
    for (int r = 0; r < 4; r++) begin
      p = 1'($urandom_range(0, 1));
      e = 1'($urandom_range(0, 1));
      code = 8'($urandom_range(0, 255));
      send_event(p, e, code, 1'b1);
      expect_all("rand");
      settle("rand");
    end

    // Six toggles on consecutive cycles: one sends, four queue, the sixth is dropped.
    ovf_base = ovf_cnt;
    for (int r = 0; r < 6; r++) begin
      p = 1'($urandom_range(0, 1));
      e = 1'($urandom_range(0, 1));
      code = 8'($urandom_range(0, 255));
      send_event(p, e, code, r < 5);
    end
    repeat (3) @(posedge clk_sys);
    #1;
    check("ovf_pulses", 32'(ovf_cnt - ovf_base), 1);
    expect_all("ovf");
    settle("ovf");

    // Host inhibit during SETUP of bit 5: lines released, whole byte resent.
    code = 8'($urandom_range(0, 255));
    send_event(1'b1, 1'b0, code, 1'b1);
    wait_bits("inh5", 5);
    wait_clk_oe("inh5_setup", 1'b0);
    host_hold = 1'b1;
    repeat (3 * CLK_DIV) @(posedge clk_sys);
    #1;
    check("inh5_clk_rel", 32'(ps2_clk_oe), 0);
    check("inh5_dat_rel", 32'(ps2_dat_oe), 0);
    check("inh5_busy", 32'(busy), 1);
    check("inh5_nbits", 32'(bits_q.size()), 5);
    check("inh5_start", 32'(bits_q[0]), 0);
    for (int j = 0; j < 4; j++) part[j] = bits_q[j + 1];
    check("inh5_partial", 32'(part), 32'(code[3:0]));
    clear_host();
    rel = cyc;
    host_hold = 1'b0;
    wait_bits("inh5_resend", 1);
    if (fall_q.size() > 0) check("inh5_backoff", 32'((fall_q[0] - rel) >= int'(CLK_DIV)), 1);
    expect_all("inh5");
    settle("inh5");

    // Host inhibit during stop-bit SETUP: byte counts as sent.
    code = 8'($urandom_range(0, 255));
    send_event(1'b1, 1'b0, code, 1'b0);
    wait_bits("inh10", 10);
    wait_clk_oe("inh10_setup", 1'b0);
    host_hold = 1'b1;
    repeat (3 * CLK_DIV) @(posedge clk_sys);
    #1;
    check("inh10_clk_rel", 32'(ps2_clk_oe), 0);
    check("inh10_dat_rel", 32'(ps2_dat_oe), 0);
    for (int j = 0; j < 8; j++) part8[j] = bits_q[j + 1];
    check("inh10_byte", 32'(part8), 32'(code));
    check("inh10_parity", 32'(bits_q[9]), 32'(odd_par(code)));
    host_hold = 1'b0;
    repeat (60) @(posedge clk_sys);
    #1;
    check("inh10_no_resend", 32'(bits_q.size()), 10);
    check("inh10_busy", 32'(busy), 0);
    clear_host();

    // Reset mid-frame while both lines are driven low.
    send_event(1'b1, 1'b1, 8'($urandom_range(0, 255)), 1'b0);
    wait_bits("rstmid", 3);
    w = 0;
    @(negedge clk_sys);
    while (!(ps2_clk_oe && ps2_dat_oe) && w < 40) begin
      @(negedge clk_sys);
      w++;
    end
    check("rstmid_driving", 32'(ps2_clk_oe && ps2_dat_oe), 1);
    #2;
    reset_n = 1'b0;
    #1;
    check("rstmid_clk_oe", 32'(ps2_clk_oe), 0);
    check("rstmid_dat_oe", 32'(ps2_dat_oe), 0);
    check("rstmid_busy", 32'(busy), 0);
    ps2_key[10] = 1'b1;
    clear_host();
    exp_q.delete();
    repeat (3) @(negedge clk_sys);
    reset_n = 1'b1;
    #1;
    check("rstmid_busy_rel", 32'(busy), 0);
    repeat (60) @(posedge clk_sys);
    #1;
    check("rstmid_stale_bits", 32'(bits_q.size()), 0);
    check("rstmid_stale_busy", 32'(busy), 0);

    // Normal operation after reset.
    send_event(1'b1, 1'b0, 8'h1C, 1'b1);
    expect_all("post_rst");
    settle("post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
